// File: rtl/ps2_rx_fifo.sv
// rtl/ps2_rx_fifo.sv - PS/2 device-to-host receiver with glitch filter, frame checks and receive FIFO.
// Optional frame watchdog enabled by defining PS2_RX_TIMEOUT_EN.
module ps2_rx_fifo #(
  parameter int FIFO_DEPTH     = 16,
  parameter int FILTER_LEN     = 4,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic                         Hclock,
  input  logic                         Hreset,
  input  logic                         ps2clk,
  input  logic                         ps2data,
  input  logic                         rdEn,
  input  logic                         clrErr,
  output logic [7:0]                   rdData,
  output logic                         empty,
  output logic                         full,
  output logic [$clog2(FIFO_DEPTH):0]  count,
  output logic                         parityErr,
  output logic                         frameErr,
  output logic                         overflow
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("FIFO_DEPTH must be a power of two >= 2");
  end
  if (FILTER_LEN < 1 || FILTER_LEN > 15) begin : g_bad_filter
    $error("FILTER_LEN must be in 1..15");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be >= 1");
  end

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  logic       clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;
  logic       filt_q;
  logic [3:0] fcnt_q;
  logic       fall_w;
  logic       timeout_w;

  state_t     state_q;
  logic [7:0] shift_q;
  logic [2:0] bitcnt_q;
  logic       par_q, perr_q;

  logic [7:0]  mem [FIFO_DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [AW:0]   cnt_q;
  logic          push_w, do_push, do_pop;
  logic          perr_set_w, ferr_set_w, ovf_set_w;
  logic          perr_flag_q, ferr_flag_q, ovf_flag_q;

  always_ff @(posedge Hclock or posedge Hreset) begin
    if (Hreset) begin
      clk_s1_q <= 1'b1;
      clk_s2_q <= 1'b1;
      dat_s1_q <= 1'b1;
      dat_s2_q <= 1'b1;
    end else begin
      clk_s1_q <= ps2clk;
      clk_s2_q <= clk_s1_q;
      dat_s1_q <= ps2data;
      dat_s2_q <= dat_s1_q;
    end
  end

  // The filtered level flips on the FILTER_LEN-th consecutive differing sample.
  always_ff @(posedge Hclock or posedge Hreset) begin
    if (Hreset) begin
      filt_q <= 1'b1;
      fcnt_q <= 4'd0;
    end else if (clk_s2_q == filt_q) begin
      fcnt_q <= 4'd0;
    end else if (fcnt_q == 4'(FILTER_LEN - 1)) begin
      filt_q <= clk_s2_q;
      fcnt_q <= 4'd0;
    end else begin
      fcnt_q <= fcnt_q + 4'd1;
    end
  end

  assign fall_w = filt_q && !clk_s2_q && (fcnt_q == 4'(FILTER_LEN - 1));

`ifdef PS2_RX_TIMEOUT_EN
  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
  logic [WW-1:0] wd_q;

  always_ff @(posedge Hclock or posedge Hreset) begin
    if (Hreset) begin
      wd_q <= '0;
    end else if (state_q == IDLE || fall_w || timeout_w) begin
      wd_q <= '0;
    end else begin
      wd_q <= wd_q + 1'b1;
    end
  end

  assign timeout_w = (state_q != IDLE) && !fall_w && (wd_q == WW'(TIMEOUT_CYCLES - 1));
`else
  assign timeout_w = 1'b0;
`endif

  always_ff @(posedge Hclock or posedge Hreset) begin
    if (Hreset) begin
      state_q  <= IDLE;
      shift_q  <= 8'h00;
      bitcnt_q <= 3'd0;
      par_q    <= 1'b0;
      perr_q   <= 1'b0;
    end else if (timeout_w) begin
      state_q <= IDLE;
    end else if (fall_w) begin
      case (state_q)
        IDLE: begin
          if (!dat_s2_q) begin
            state_q  <= DATA;
            bitcnt_q <= 3'd0;
            par_q    <= 1'b0;
          end
        end
        DATA: begin
          shift_q  <= {dat_s2_q, shift_q[7:1]};
          par_q    <= par_q ^ dat_s2_q;
          bitcnt_q <= bitcnt_q + 3'd1;
          if (bitcnt_q == 3'd7) state_q <= PARITY;
        end
        PARITY: begin
          perr_q  <= ~(par_q ^ dat_s2_q);
          state_q <= STOP;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Stop-bit outcomes act in the same cycle as the fall edge so results land one edge later.
  assign push_w     = fall_w && (state_q == STOP) && dat_s2_q && !perr_q;
  assign perr_set_w = fall_w && (state_q == STOP) && dat_s2_q && perr_q;
  assign ferr_set_w = (fall_w && (state_q == STOP) && !dat_s2_q) || timeout_w;

  assign do_pop    = rdEn && (cnt_q != '0);
  assign do_push   = push_w && ((cnt_q != DEPTH_C) || do_pop);
  assign ovf_set_w = push_w && (cnt_q == DEPTH_C) && !do_pop;

  always_ff @(posedge Hclock) begin
    if (do_push) mem[wptr_q] <= shift_q;
  end

  always_ff @(posedge Hclock or posedge Hreset) begin
    if (Hreset) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
      if (do_push && !do_pop)      cnt_q <= cnt_q + 1'b1;
      else if (do_pop && !do_push) cnt_q <= cnt_q - 1'b1;
    end
  end

  always_ff @(posedge Hclock or posedge Hreset) begin
    if (Hreset) begin
      perr_flag_q <= 1'b0;
      ferr_flag_q <= 1'b0;
      ovf_flag_q  <= 1'b0;
    end else begin
      perr_flag_q <= (perr_flag_q && !clrErr) || perr_set_w;
      ferr_flag_q <= (ferr_flag_q && !clrErr) || ferr_set_w;
      ovf_flag_q  <= (ovf_flag_q  && !clrErr) || ovf_set_w;
    end
  end

  assign empty     = (cnt_q == '0);
  assign full      = (cnt_q == DEPTH_C);
  assign count     = cnt_q;
  assign rdData    = empty ? 8'h00 : mem[rptr_q];
  assign parityErr = perr_flag_q;
  assign frameErr  = ferr_flag_q;
  assign overflow  = ovf_flag_q;

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// tb/tb_ps2_rx_fifo.sv - self-checking bench for ps2_rx_fifo (FIFO_DEPTH=4, FILTER_LEN=4).
module tb_ps2_rx_fifo;
  logic       Hclock = 1'b0;
  logic       Hreset = 1'b1;
  logic       ps2clk = 1'b1;
  logic       ps2data = 1'b1;
  logic       rdEn = 1'b0;
  logic       clrErr = 1'b0;
  logic [7:0] rdData;
  logic       empty, full, parityErr, frameErr, overflow;
  logic [2:0] count;

  int total = 0;
  int bad = 0;
  logic [7:0] exp_q[$];

  ps2_rx_fifo #(.FIFO_DEPTH(4), .FILTER_LEN(4), .TIMEOUT_CYCLES(1000)) dut (
    .Hclock(Hclock), .Hreset(Hreset), .ps2clk(ps2clk), .ps2data(ps2data),
    .rdEn(rdEn), .clrErr(clrErr), .rdData(rdData), .empty(empty), .full(full),
    .count(count), .parityErr(parityErr), .frameErr(frameErr), .overflow(overflow)
  );

  always #5 Hclock = ~Hclock;

  typedef struct {
    logic [7:0] data;
    logic       bad_par;
    logic       stop;
    logic       exp_perr;
    logic       exp_ferr;
    logic       exp_push;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge Hclock);
  endtask

  task automatic send_bit(input logic b);
    @(negedge Hclock);
    ps2data = b;
    wait_cyc(8);
    ps2clk = 1'b0;
    wait_cyc(8);
    ps2clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic bad_par, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit((~^d) ^ bad_par);
    send_bit(stop);
    ps2data = 1'b1;
    wait_cyc(10);
  endtask

  task automatic pop_check(input string name);
    logic [7:0] e;
    @(negedge Hclock);
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL %s: scoreboard empty, rdData=%0h", name, rdData);
    end else begin
      e = exp_q.pop_front();
      check(name, int'(rdData), int'(e));
    end
    rdEn = 1'b1;
    @(negedge Hclock);
    rdEn = 1'b0;
  endtask

  task automatic pulse_clr();
    @(negedge Hclock);
    clrErr = 1'b1;
    @(negedge Hclock);
    clrErr = 1'b0;
  endtask

  initial begin
    vecs[0] = '{8'h1C, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[1] = '{8'hF0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{8'hF0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[3] = '{8'h5A, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[4] = '{8'h29, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[5] = '{8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[6] = '{8'hFF, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[7] = '{8'hA5, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};

    wait_cyc(3);
    check("rst_rdData", int'(rdData), 0);
    check("rst_empty", int'(empty), 1);
    check("rst_full", int'(full), 0);
    check("rst_count", int'(count), 0);
    check("rst_flags", int'({parityErr, frameErr, overflow}), 0);
    Hreset = 1'b0;
    wait_cyc(5);

    for (int i = 0; i < 8; i++) begin
      pulse_clr();
      check($sformatf("v%0d_clr", i), int'({parityErr, frameErr}), 0);
      send_frame(vecs[i].data, vecs[i].bad_par, vecs[i].stop);
      if (vecs[i].exp_push) exp_q.push_back(vecs[i].data);
      check($sformatf("v%0d_perr", i), int'(parityErr), int'(vecs[i].exp_perr));
      check($sformatf("v%0d_ferr", i), int'(frameErr), int'(vecs[i].exp_ferr));
      check($sformatf("v%0d_count", i), int'(count), vecs[i].exp_push ? 1 : 0);
      while (exp_q.size() > 0) pop_check($sformatf("v%0d_data", i));
      check($sformatf("v%0d_empty", i), int'(empty), 1);
      check($sformatf("v%0d_rd0", i), int'(rdData), 0);
    end

    pulse_clr();
    for (int i = 1; i <= 5; i++) begin
      send_frame(8'(i), 1'b0, 1'b1);
      if (i <= 4) exp_q.push_back(8'(i));
      if (i == 4) begin
        check("ovf_full4", int'(full), 1);
        check("ovf_none4", int'(overflow), 0);
      end
    end
    check("ovf_set", int'(overflow), 1);
    check("ovf_count", int'(count), 4);
    for (int i = 0; i < 4; i++) pop_check("ovf_pop");
    @(negedge Hclock);
    check("ovf_empty", int'(empty), 1);
    check("ovf_rd0", int'(rdData), 0);
    pulse_clr();
    check("ovf_clr", int'(overflow), 0);

    @(negedge Hclock);
    ps2data = 1'b0;
    wait_cyc(4);
    ps2clk = 1'b0;
    wait_cyc(3);
    ps2clk = 1'b1;
    wait_cyc(12);
    send_frame(8'h1C, 1'b0, 1'b1);
    exp_q.push_back(8'h1C);
    check("gl_count", int'(count), 1);
    check("gl_flags", int'({parityErr, frameErr}), 0);
    pop_check("gl_data");

    send_frame(8'h11, 1'b0, 1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    @(negedge Hclock);
    Hreset = 1'b1;
    wait_cyc(2);
    check("mr_empty", int'(empty), 1);
    check("mr_count", int'(count), 0);
    Hreset = 1'b0;
    wait_cyc(5);
    send_frame(8'h29, 1'b0, 1'b1);
    exp_q.push_back(8'h29);
    check("mr_flags", int'({parityErr, frameErr}), 0);
    pop_check("mr_data");

`ifdef PS2_RX_TIMEOUT_EN
    pulse_clr();
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    ps2data = 1'b1;
    wait_cyc(900);
    check("wd_early", int'(frameErr), 0);
    wait_cyc(150);
    check("wd_ferr", int'(frameErr), 1);
    check("wd_nopush", int'(empty), 1);
    pulse_clr();
    send_frame(8'h29, 1'b0, 1'b1);
    exp_q.push_back(8'h29);
    check("wd_next_flags", int'({parityErr, frameErr}), 0);
    pop_check("wd_next_data");
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached, got running want finished");
    $fatal(1);
  end
endmodule
